// File: rtl/norm_shift_ctrl.sv
// Multi-cycle leading-one scanner producing shift controls for the mantissa/exponent normalizer.
// Optional exponent clamp to subnormal range: define NORM_EXP_CLAMP_EN.
module norm_shift_ctrl #(
    parameter int unsigned MANTISSA_N     = 25,
    parameter int unsigned EXP_N          = 8,
    parameter int unsigned FILL_TO        = 32,
    parameter int unsigned BITS_PER_CYCLE = 4,
    localparam int unsigned SA_W          = $clog2(FILL_TO)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [MANTISSA_N-1:0] Mantissa,
    input  logic [EXP_N-1:0]      Exp,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [MANTISSA_N-1:0] MantissaOut,
    output logic [EXP_N-1:0]      ExpOut,
    output logic                  SREn,
    output logic                  SLEn,
    output logic [SA_W-1:0]       ShiftAmount,
    output logic                  ZeroFlag,
    output logic                  DenormFlag
);

    localparam int unsigned TOP = MANTISSA_N - 2;
    localparam int unsigned PW  = $clog2(MANTISSA_N);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_e;

    state_e                  state_q;
    logic [PW-1:0]           ptr_q;
    logic                    first_q;
    logic [MANTISSA_N-1:0]   mant_q;
    logic [EXP_N-1:0]        exp_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    sre_q;
    logic                    sle_q;
    logic [SA_W-1:0]         sa_q;
    logic                    zero_q;
    logic                    den_q;

    logic                    hit_c;
    logic [PW-1:0]           q_c;
    logic                    last_c;
    logic [SA_W-1:0]         lzc_c;
    logic [SA_W-1:0]         sa_fin_c;
    logic                    den_c;

    // Highest set bit inside the current window [ptr, ptr-BITS_PER_CYCLE+1]
    always_comb begin
        hit_c = 1'b0;
        q_c   = '0;
        for (int i = 0; i <= int'(TOP); i++) begin
            if (mant_q[i] && (i <= int'(ptr_q)) &&
                (i > int'(ptr_q) - int'(BITS_PER_CYCLE))) begin
                hit_c = 1'b1;
                q_c   = PW'(i);
            end
        end
        last_c = (int'(ptr_q) < int'(BITS_PER_CYCLE));
        lzc_c  = SA_W'(int'(TOP) - int'(q_c));
    end

`ifdef NORM_EXP_CLAMP_EN
    int exp_s_c;

    // Limit the left shift so the resulting exponent never drops below 1
    always_comb begin
        exp_s_c  = int'($signed(exp_q));
        sa_fin_c = lzc_c;
        den_c    = 1'b0;
        if (exp_s_c - int'(lzc_c) < 1) begin
            sa_fin_c = (exp_s_c > 1) ? SA_W'(exp_s_c - 1) : '0;
            den_c    = 1'b1;
        end
    end
`else
    always_comb begin
        sa_fin_c = lzc_c;
        den_c    = 1'b0;
    end
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            first_q     <= 1'b0;
            mant_q      <= '0;
            exp_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sre_q       <= 1'b0;
            sle_q       <= 1'b0;
            sa_q        <= '0;
            zero_q      <= 1'b0;
            den_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (InValid && in_ready_q) begin
                        mant_q     <= Mantissa;
                        exp_q      <= Exp;
                        ptr_q      <= PW'(TOP);
                        first_q    <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    first_q <= 1'b0;
                    // Carry overrides any leading-one result
                    if (first_q && mant_q[MANTISSA_N-1]) begin
                        sre_q       <= 1'b1;
                        sle_q       <= 1'b0;
                        sa_q        <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (hit_c) begin
                        sre_q       <= 1'b0;
                        sle_q       <= 1'b1;
                        sa_q        <= sa_fin_c;
                        den_q       <= den_c;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (last_c) begin
                        sre_q       <= 1'b0;
                        sle_q       <= 1'b0;
                        sa_q        <= '0;
                        zero_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        ptr_q <= ptr_q - PW'(BITS_PER_CYCLE);
                    end
                end
                HOLD: begin
                    if (OutReady) begin
                        out_valid_q <= 1'b0;
                        sre_q       <= 1'b0;
                        sle_q       <= 1'b0;
                        sa_q        <= '0;
                        zero_q      <= 1'b0;
                        den_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign InReady     = in_ready_q;
    assign OutValid    = out_valid_q;
    assign MantissaOut = mant_q;
    assign ExpOut      = exp_q;
    assign SREn        = sre_q;
    assign SLEn        = sle_q;
    assign ShiftAmount = sa_q;
    assign ZeroFlag    = zero_q;
    assign DenormFlag  = den_q;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Scoreboard bench for norm_shift_ctrl: random operands checked against a leading-zero reference model.
module tb_norm_shift_ctrl;

    localparam int MN  = 25;
    localparam int EN  = 8;
    localparam int BPC = 4;
    localparam int SAW = 5;

    logic           Clock = 1'b0;
    logic           Reset = 1'b1;
    logic           InValid = 1'b0;
    logic           InReady;
    logic [MN-1:0]  Mantissa = '0;
    logic [EN-1:0]  Exp = '0;
    logic           OutValid;
    logic           OutReady = 1'b0;
    logic [MN-1:0]  MantissaOut;
    logic [EN-1:0]  ExpOut;
    logic           SREn;
    logic           SLEn;
    logic [SAW-1:0] ShiftAmount;
    logic           ZeroFlag;
    logic           DenormFlag;

    norm_shift_ctrl dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Mantissa(Mantissa), .Exp(Exp), .OutValid(OutValid), .OutReady(OutReady),
        .MantissaOut(MantissaOut), .ExpOut(ExpOut), .SREn(SREn), .SLEn(SLEn),
        .ShiftAmount(ShiftAmount), .ZeroFlag(ZeroFlag), .DenormFlag(DenormFlag)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic          sre;
        logic          sle;
        logic          zero;
        logic          den;
        int            sa;
        logic [MN-1:0] mant;
        logic [EN-1:0] ex;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rdy_pct = 100;
    logic seen = 1'b0;
    int   vcyc = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: normalise by locating the most significant set bit below the carry
    function automatic exp_t model(input logic [MN-1:0] m, input logic [EN-1:0] ex);
        exp_t r;
        int   q;
        int   e;
        r.sre = 0; r.sle = 0; r.zero = 0; r.den = 0; r.sa = 0;
        r.mant = m; r.ex = ex; r.lat = 0;
        q = -1;
        e = int'($signed(ex));
        if (m[MN-1]) begin
            r.sre = 1; r.lat = 1;
        end else begin
            for (int i = 0; i <= MN - 2; i++) if (m[i]) q = i;
            if (q < 0) begin
                r.zero = 1; r.lat = (MN - 1 + BPC - 1) / BPC;
            end else begin
                r.sle = 1; r.sa = (MN - 2) - q; r.lat = ((MN - 2) - q) / BPC + 1;
`ifdef NORM_EXP_CLAMP_EN
                if (e - r.sa < 1) begin
                    r.sa  = (e > 1) ? e - 1 : 0;
                    r.den = 1;
                end
`endif
            end
        end
        return r;
    endfunction

    always @(posedge Clock) begin
        #1;
        OutReady = ($urandom_range(0, 99) < rdy_pct);
    end

    // Monitor: compares every presented output against the scoreboard head
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset) begin
            if (InValid && InReady) acc_q.push_back(cyc);
            if (OutValid) begin
                if (!seen) begin
                    seen = 1'b1;
                    vcyc = cyc;
                end
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sb[0];
                    check("sre", int'(SREn), int'(e.sre));
                    check("sle", int'(SLEn), int'(e.sle));
                    check("shift_amount", int'(ShiftAmount), e.sa);
                    check("zero_flag", int'(ZeroFlag), int'(e.zero));
                    check("denorm_flag", int'(DenormFlag), int'(e.den));
                    check("mantissa_out", int'(MantissaOut), int'(e.mant));
                    check("exp_out", int'(ExpOut), int'(e.ex));
                    check("in_ready_hold", int'(InReady), 0);
                    if (OutReady) begin
                        if (acc_q.size() == 0) check("accept_record", 0, 1);
                        else check("latency", vcyc - acc_q.pop_front(), e.lat + 1);
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [MN-1:0] m, input logic [EN-1:0] ex);
        int n;
        sb.push_back(model(m, ex));
        @(posedge Clock);
        #1;
        Mantissa = m;
        Exp      = ex;
        InValid  = 1'b1;
        n = 0;
        @(negedge Clock);
        while (!InReady && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 200) check("accept_timeout", 0, 1);
        @(posedge Clock);
        #1;
        InValid = ($urandom_range(0, 3) == 0);
        Mantissa = MN'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 500) check("drain_timeout", 0, 1);
        InValid = 1'b0;
    endtask

    initial begin
        logic [MN-1:0] m;
        int            k;
        int            n;

        #12;
        check("rst_in_ready", int'(InReady), 1);
        check("rst_out_valid", int'(OutValid), 0);
        check("rst_sre", int'(SREn), 0);
        check("rst_sle", int'(SLEn), 0);
        check("rst_sa", int'(ShiftAmount), 0);
        check("rst_zero", int'(ZeroFlag), 0);
        check("rst_den", int'(DenormFlag), 0);
        check("rst_mant", int'(MantissaOut), 0);
        check("rst_exp", int'(ExpOut), 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        issue(25'h1000000, 8'd10);
        wait_drain();
        issue(25'h0800000, 8'd30);
        wait_drain();
        issue(25'h0000001, 8'd40);
        wait_drain();
        issue(25'h0000000, 8'd3);
        wait_drain();

        // Downstream stall: outputs must hold, then one IDLE cycle with InReady high
        rdy_pct = 0;
        issue(25'h0000100, 8'd5);
        n = 0;
        while (!OutValid && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("hold_valid_seen", int'(OutValid), 1);
        repeat (3) @(negedge Clock);
        rdy_pct = 100;
        @(negedge Clock);
        @(negedge Clock);
        check("bubble_in_ready", int'(InReady), 1);
        check("bubble_out_valid", int'(OutValid), 0);
        wait_drain();

        // Reset in the middle of a scan drops the operand
        issue(25'h0000001, 8'd20);
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        #1;
        check("midrst_in_ready", int'(InReady), 1);
        check("midrst_out_valid", int'(OutValid), 0);
        check("midrst_sle", int'(SLEn), 0);
        check("midrst_sa", int'(ShiftAmount), 0);
        check("midrst_mant", int'(MantissaOut), 0);
        check("midrst_exp", int'(ExpOut), 0);
        sb.delete();
        acc_q.delete();
        seen = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        rdy_pct = 60;
        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                m = MN'($urandom);
                m[MN-1] = 1'b1;
            end else if (k == 1) begin
                m = '0;
            end else begin
                n = $urandom_range(0, MN - 2);
                m = MN'((1 << n) | ($urandom & ((1 << n) - 1)));
            end
            issue(m, EN'($urandom));
        end
        wait_drain();
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
